fpu_divider: RTL and testbench

Unsigned restoring integer divider, iterative, one quotient bit per clock. Used as the mantissa/integer divide engine inside the FPU. It accepts a dividend/divisor pair on a start pulse and runs WIDTH iterations. It then raises done, with quotient and remainder held stable until the next start or reset.

---
 rtl/fpu_divider_pkg.sv | 15 +
 rtl/fpu_divider_fsm.sv | 58 +++++
 rtl/fpu_divider.sv | 52 +++++
 tb/tb_fpu_divider.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fpu_divider_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package fpu_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fpu_divider_fsm.sv
// Sequencer for the divider: accepts start, counts iterations, flags done.
module fpu_divider_fsm
  import fpu_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic load,
  output logic step,
  output logic done
);

  localparam int CW = cnt_width(WIDTH);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // RUN performs WIDTH steps, then spends one extra cycle moving into DONE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          cnt_next   = CW'(WIDTH);
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg != '0) begin
          step     = 1'b1;
          cnt_next = cnt_reg - CW'(1);
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign done = (state_reg == DONE);

endmodule

// File: rtl/fpu_divider.sv
// Unsigned restoring divider, one quotient bit per clock; datapath plus FSM.
module fpu_divider
  import fpu_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] divIn1,
  input  logic [WIDTH-1:0] divIn2,
  output logic [WIDTH-1:0] divOut,
  output logic [WIDTH-1:0] divRem,
  output logic             done
);

  logic             load, step;
  logic [WIDTH-1:0] quo_reg, rem_reg, div_reg;
  logic [WIDTH:0]   rem_shifted, trial;

  fpu_divider_fsm #(.WIDTH(WIDTH)) FSM (
    .clock (clock),
    .reset (reset),
    .start (start),
    .load  (load),
    .step  (step),
    .done  (done)
  );

  // rem < divisor always holds, so trial's MSB is a valid borrow/sign bit.
  assign rem_shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign trial       = rem_shifted - {1'b0, div_reg};

  always_ff @(posedge clock) begin
    if (reset) begin
      quo_reg <= '0;
      rem_reg <= '0;
      div_reg <= '0;
    end else if (load) begin
      quo_reg <= divIn1;
      rem_reg <= '0;
      div_reg <= divIn2;
    end else if (step) begin
      quo_reg <= {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
      rem_reg <= trial[WIDTH] ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end
  end

  assign divOut = quo_reg;
  assign divRem = rem_reg;

endmodule

// File: tb/tb_fpu_divider.sv
// Directed and randomized checks of fpu_divider at WIDTH=8.
module tb_fpu_divider;
  import fpu_divider_pkg::*;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] divIn1, divIn2;
  logic [WIDTH-1:0] divOut, divRem;
  logic             done;

  int tests_run = 0;
  int tests_failed = 0;

  fpu_divider #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .divIn1 (divIn1),
    .divIn2 (divIn2),
    .divOut (divOut),
    .divRem (divRem),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Launch a division, scramble operands after acceptance, check exact latency and result.
  task automatic div_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er);
    @(negedge clock);
    divIn1 = a;
    divIn2 = b;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start  = 1'b0;
    divIn1 = 8'($urandom);
    divIn2 = 8'($urandom);
    repeat (WIDTH) @(posedge clock);
    @(negedge clock);
    check({tag, ".done_early"}, 32'(done), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".quo"}, 32'(divOut), 32'(eq));
    check({tag, ".rem"}, 32'(divRem), 32'(er));
    $display("[TB] %s: %0d / %0d -> q=%0d r=%0d (exp q=%0d r=%0d)", tag, a, b, divOut, divRem, eq, er);
  endtask

  initial begin
    logic [7:0] ra, rb, rq, rr;
    reset  = 1'b1;
    start  = 1'b0;
    divIn1 = '0;
    divIn2 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst.done", 32'(done), 32'd0);
    check("rst.quo", 32'(divOut), 32'd0);
    check("rst.rem", 32'(divRem), 32'd0);
    check("rst.state", 32'(dut.FSM.state_reg), 32'(IDLE));

    div_op("d100_7", 8'd100, 8'd7, 8'd14, 8'd2);
    div_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0);
    div_op("d5_10", 8'd5, 8'd10, 8'd0, 8'd5);
    div_op("d0_3", 8'd0, 8'd3, 8'd0, 8'd0);
    div_op("d77_0", 8'd77, 8'd0, 8'd255, 8'd77);

    // Abort a division three cycles in.
    @(negedge clock);
    divIn1 = 8'd200;
    divIn2 = 8'd3;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("abort.done", 32'(done), 32'd0);
    check("abort.quo", 32'(divOut), 32'd0);
    check("abort.rem", 32'(divRem), 32'd0);
    check("abort.state", 32'(dut.FSM.state_reg), 32'(IDLE));
    repeat (12) @(posedge clock);
    @(negedge clock);
    check("abort.idle_done", 32'(done), 32'd0);
    div_op("d200_3", 8'd200, 8'd3, 8'd66, 8'd2);

    // Hold start high through RUN: no restart until DONE is reached.
    @(negedge clock);
    divIn1 = 8'd50;
    divIn2 = 8'd6;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    divIn1 = 8'd250;
    divIn2 = 8'd1;
    repeat (WIDTH) @(posedge clock);
    @(negedge clock);
    check("hold.done_early", 32'(done), 32'd0);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("hold.done", 32'(done), 32'd1);
    check("hold.quo", 32'(divOut), 32'd8);
    check("hold.rem", 32'(divRem), 32'd2);
    $display("[TB] hold: 50 / 6 -> q=%0d r=%0d (exp q=8 r=2)", divOut, divRem);

    // Back-to-back launch from DONE drops done on the accepting edge.
    divIn1 = 8'd9;
    divIn2 = 8'd4;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("b2b.done_drop", 32'(done), 32'd0);
    repeat (WIDTH) @(posedge clock);
    @(negedge clock);
    check("b2b.done_early", 32'(done), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("b2b.done", 32'(done), 32'd1);
    check("b2b.quo", 32'(divOut), 32'd2);
    check("b2b.rem", 32'(divRem), 32'd1);
    $display("[TB] b2b: 9 / 4 -> q=%0d r=%0d (exp q=2 r=1)", divOut, divRem);

    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom);
      rb = (i % 10 == 0) ? 8'd0 : 8'($urandom);
      rq = (rb == 0) ? 8'hFF : ra / rb;
      rr = (rb == 0) ? ra : ra % rb;
      pulse_reset();
      div_op($sformatf("rnd%0d", i), ra, rb, rq, rr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
